// File: rtl/wait_timer_if.sv
// wait_timer_if: handshake bundle between a wait_timer and its controller/divider (periodic only with WAIT_TIMER_PERIODIC_EN)
interface wait_timer_if #(parameter int W = 16);
  logic         start;
  logic [W-1:0] ticks;
  logic         abort;
  logic         tick;
  logic         timer_ena;
  logic         busy;
  logic         done;
  logic [W-1:0] remaining;
`ifdef WAIT_TIMER_PERIODIC_EN
  logic         periodic;
  modport master (output start, ticks, abort, tick, periodic, input timer_ena, busy, done, remaining);
  modport slave  (input start, ticks, abort, tick, periodic, output timer_ena, busy, done, remaining);
`else
  modport master (output start, ticks, abort, tick, input timer_ena, busy, done, remaining);
  modport slave  (input start, ticks, abort, tick, output timer_ena, busy, done, remaining);
`endif
endinterface

// File: rtl/wait_timer.sv
// wait_timer: counts a programmed number of divider ticks and pulses done once
// WAIT_TIMER_PERIODIC_EN adds a latched periodic mode that reloads the count and keeps running
module wait_timer #(
  parameter int W = 16
) (
  input  logic       clk,
  input  logic       rstn,
  wait_timer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         last_tick;
`ifdef WAIT_TIMER_PERIODIC_EN
  logic [W-1:0] reload_q, reload_d;
  logic         periodic_q, periodic_d;
`endif
  // cnt is never 0 while running, so <=1 also keeps the decrement from wrapping
  assign last_tick = cnt_q <= W'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef WAIT_TIMER_PERIODIC_EN
    reload_d   = reload_q;
    periodic_d = periodic_q;
`endif
    if (state_q == IDLE) begin
      if (bus.start && bus.ticks != '0) begin
        state_d = RUN;
        cnt_d   = bus.ticks;
`ifdef WAIT_TIMER_PERIODIC_EN
        reload_d   = bus.ticks;
        periodic_d = bus.periodic;
`endif
      end else if (bus.start) begin
        done_d = 1'b1;
      end
    end else if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (bus.tick) begin
      if (!last_tick) begin
        cnt_d = cnt_q - W'(1);
      end else begin
        done_d = 1'b1;
`ifdef WAIT_TIMER_PERIODIC_EN
        cnt_d   = periodic_q ? reload_q : '0;
        state_d = periodic_q ? RUN : IDLE;
`else
        cnt_d   = '0;
        state_d = IDLE;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef WAIT_TIMER_PERIODIC_EN
      reload_q   <= '0;
      periodic_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef WAIT_TIMER_PERIODIC_EN
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
`endif
    end
  end
  assign bus.timer_ena = state_q == RUN;
  assign bus.busy      = state_q == RUN;
  assign bus.done      = done_q;
  assign bus.remaining = cnt_q;
endmodule
